// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory write arbiter.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed m0 priority instead of round-robin).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  localparam int MAX_BURST_DEF = 4;

  // Beat counter must hold 0..max_burst inclusive.
  function automatic int bcnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Next-owner selection for mem_arbiter: pure combinational, no state of its own.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (m0 always wins; last and burst limit ignored).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic [1:0] state,
  input  logic       last,
  input  logic       limit_hit,
  output logic [1:0] next_state
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{state, last, limit_hit};

  always_comb begin
    next_state = IDLE;
    if (m0_req) begin
      next_state = G0;
    end else if (m1_req) begin
      next_state = G1;
    end
  end
`else
  // The owner yields early only when the other side is waiting; otherwise it keeps a saturated grant.
  always_comb begin
    next_state = IDLE;
    case (state)
      G0: begin
        if (m1_req && (!m0_req || limit_hit)) begin
          next_state = G1;
        end else if (m0_req) begin
          next_state = G0;
        end
      end
      G1: begin
        if (m0_req && (!m1_req || limit_hit)) begin
          next_state = G0;
        end else if (m1_req) begin
          next_state = G1;
        end
      end
      default: begin
        if (m0_req && m1_req) begin
          next_state = last ? G0 : G1;
        end else if (m0_req) begin
          next_state = G0;
        end else if (m1_req) begin
          next_state = G1;
        end
      end
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master write-port arbiter in front of mem_ctrl: round-robin grants with a burst cap,
// one registered write per beat. Optional build macro: MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_data,
  output logic          m0_gnt,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_data,
  output logic          m1_gnt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          mem_src
);

  localparam int            BW       = bcnt_width(MAX_BURST);
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [1:0]    pick_next;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_beat;
  logic          last_q, last_d;
  logic          beat0, beat1, limit_hit, entering;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_src_q, mem_src_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = arb_state_e'(pick_next);
  end

  always_comb begin
    m0_gnt = (state_q == G0);
    m1_gnt = (state_q == G1);
    beat0  = m0_req && m0_gnt;
    beat1  = m1_req && m1_gnt;
  end

  // Limit is judged on the count including this edge's beat, so a switch lands without a gap cycle.
  always_comb begin
    bcnt_beat = bcnt_q;
    if ((beat0 || beat1) && (bcnt_q != BCNT_MAX)) begin
      bcnt_beat = bcnt_q + BW'(1);
    end
    limit_hit = (bcnt_beat == BCNT_MAX);
  end

  mem_arb_pick u_pick (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .state      (state_q),
    .last       (last_q),
    .limit_hit  (limit_hit),
    .next_state (pick_next)
  );

  always_comb begin
    entering   = (state_d != state_q) && (state_d != IDLE);
    bcnt_d     = (entering || (state_d == IDLE)) ? '0 : bcnt_beat;
    last_d     = entering ? (state_d == G1) : last_q;
    mem_we_d   = beat0 || beat1;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_src_d  = mem_src_q;
    if (beat0) begin
      mem_addr_d = m0_addr;
      mem_data_d = m0_data;
      mem_src_d  = 1'b0;
    end else if (beat1) begin
      mem_addr_d = m1_addr;
      mem_data_d = m1_data;
      mem_src_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q     <= '0;
      last_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_src_q  <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      last_q     <= last_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_src_q  <= mem_src_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign mem_src  = mem_src_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_BURST=4); honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic        m0_gnt, m1_gnt;
  logic [31:0] mem_addr, mem_data;
  logic        mem_we, mem_src;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic g0_prev, g1_prev;

  mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_data  (m0_data),
    .m0_gnt   (m0_gnt),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_data  (m1_data),
    .m1_gnt   (m1_gnt),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_src  (mem_src)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Remember grants seen before the edge so the masters know whether their beat was taken.
  task automatic tick();
    g0_prev = m0_gnt;
    g1_prev = m1_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic advance_masters();
    if (m0_req && g0_prev) begin
      m0_addr += 32'd4;
      m0_data += 32'd4;
    end
    if (m1_req && g1_prev) begin
      m1_addr += 32'd4;
      m1_data += 32'd4;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    m0_addr = '0; m0_data = '0; m1_addr = '0; m1_data = '0;
    do_reset();
    n_checks++; if (m0_gnt !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_m0_gnt: got %b want 0", m0_gnt); end
    n_checks++; if (m1_gnt !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_m1_gnt: got %b want 0", m1_gnt); end
    n_checks++; if (mem_we !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_data !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_mem_data: got %h want 0", mem_data); end
    n_checks++; if (mem_src !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mem_src: got %b want 0", mem_src); end
  endtask

  task automatic test_single_m0();
    m0_addr = 32'h10; m0_data = 32'hA10; m0_req = 1'b1;
    tick();
    n_checks++; if (m0_gnt !== 1'b1) begin n_fails++; $display("[TB] FAIL single_gnt_rise: got %b want 1", m0_gnt); end
    n_checks++; if (mem_we !== 1'b0) begin n_fails++; $display("[TB] FAIL single_no_early_we: got %b want 0", mem_we); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_we !== 1'b1) begin n_fails++; $display("[TB] FAIL single_we[%0d]: got %b want 1", i, mem_we); end
      n_checks++; if (mem_addr !== 32'h10 + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL single_addr[%0d]: got %h want %h", i, mem_addr, 32'h10 + 32'(4 * i)); end
      n_checks++; if (mem_data !== 32'hA10 + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL single_data[%0d]: got %h want %h", i, mem_data, 32'hA10 + 32'(4 * i)); end
      n_checks++; if (mem_src !== 1'b0) begin n_fails++; $display("[TB] FAIL single_src[%0d]: got %b want 0", i, mem_src); end
      if (i == 2) m0_req = 1'b0;
      else advance_masters();
    end
    tick();
    n_checks++; if (mem_we !== 1'b0) begin n_fails++; $display("[TB] FAIL single_we_end: got %b want 0", mem_we); end
    n_checks++; if (m0_gnt !== 1'b0) begin n_fails++; $display("[TB] FAIL single_gnt_end: got %b want 0", m0_gnt); end
    n_checks++; if (mem_addr !== 32'h18) begin n_fails++; $display("[TB] FAIL single_addr_hold: got %h want 00000018", mem_addr); end
  endtask

  task automatic test_both_idle();
    do_reset();
    m0_addr = 32'h40; m0_data = 32'h400; m1_addr = 32'h80; m1_data = 32'h800;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fails++; $display("[TB] FAIL tie_first_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    tick();
    n_checks++; if ({mem_we, mem_src} !== 2'b10) begin n_fails++; $display("[TB] FAIL tie_m0_beat we/src: got %b want 10", {mem_we, mem_src}); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fails++; $display("[TB] FAIL tie_m0_addr: got %h want 00000040", mem_addr); end
    m0_req = 1'b0;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b010) begin n_fails++; $display("[TB] FAIL tie_handover gnt0/gnt1/we: got %b want 010", {m0_gnt, m1_gnt, mem_we}); end
    tick();
    n_checks++; if ({mem_we, mem_src} !== 2'b11) begin n_fails++; $display("[TB] FAIL tie_m1_beat we/src: got %b want 11", {mem_we, mem_src}); end
    n_checks++; if (mem_data !== 32'h800) begin n_fails++; $display("[TB] FAIL tie_m1_data: got %h want 00000800", mem_data); end
    m1_req = 1'b0;
    tick();
    n_checks++; if ({m1_gnt, mem_we} !== 2'b00) begin n_fails++; $display("[TB] FAIL tie_idle gnt1/we: got %b want 00", {m1_gnt, mem_we}); end
  endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    m1_addr = 32'h700; m1_data = 32'h7000; m1_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({m1_gnt, mem_we, mem_src} !== 3'b111) begin n_fails++; $display("[TB] FAIL fixed_m1_beat[%0d] gnt1/we/src: got %b want 111", i, {m1_gnt, mem_we, mem_src}); end
      advance_masters();
    end
    m0_addr = 32'h900; m0_data = 32'h9000; m0_req = 1'b1;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fails++; $display("[TB] FAIL fixed_preempt gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_checks++; if ({mem_we, mem_src} !== 2'b11) begin n_fails++; $display("[TB] FAIL fixed_last_m1 we/src: got %b want 11", {mem_we, mem_src}); end
    advance_masters();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if ({m0_gnt, mem_we, mem_src} !== 3'b110) begin n_fails++; $display("[TB] FAIL fixed_m0_hold[%0d] gnt0/we/src: got %b want 110", i, {m0_gnt, mem_we, mem_src}); end
      n_checks++; if (mem_addr !== 32'h900 + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL fixed_m0_addr[%0d]: got %h want %h", i, mem_addr, 32'h900 + 32'(4 * i)); end
      advance_masters();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask
`else
  task automatic test_stream();
    int c0 = 0;
    int c1 = 0;
    logic        exp_src;
    logic [31:0] exp_addr;
    do_reset();
    m0_addr = 32'h100; m0_data = 32'hD0000100; m1_addr = 32'h200; m1_data = 32'hE0000200;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_checks++; if (m0_gnt !== 1'b1) begin n_fails++; $display("[TB] FAIL stream_first_gnt: got %b want 1", m0_gnt); end
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_src  = ((i / 4) % 2) == 1;
      exp_addr = exp_src ? 32'h200 + 32'(4 * c1) : 32'h100 + 32'(4 * c0);
      n_checks++; if ({mem_we, mem_src} !== {1'b1, exp_src}) begin n_fails++; $display("[TB] FAIL stream_beat[%0d] we/src: got %b want %b", i, {mem_we, mem_src}, {1'b1, exp_src}); end
      n_checks++; if (mem_addr !== exp_addr) begin n_fails++; $display("[TB] FAIL stream_addr[%0d]: got %h want %h", i, mem_addr, exp_addr); end
      if (exp_src) c1++;
      else c0++;
      advance_masters();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    m1_addr = 32'h300; m1_data = 32'h3000; m1_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if ({m1_gnt, mem_we, mem_src} !== 3'b111) begin n_fails++; $display("[TB] FAIL sat_m1_beat[%0d] gnt1/we/src: got %b want 111", i, {m1_gnt, mem_we, mem_src}); end
      n_checks++; if (mem_addr !== 32'h300 + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL sat_m1_addr[%0d]: got %h want %h", i, mem_addr, 32'h300 + 32'(4 * i)); end
      advance_masters();
    end
    m0_addr = 32'h500; m0_data = 32'h5000; m0_req = 1'b1;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fails++; $display("[TB] FAIL sat_cutoff gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_checks++; if ({mem_we, mem_src} !== 2'b11) begin n_fails++; $display("[TB] FAIL sat_cut_beat we/src: got %b want 11", {mem_we, mem_src}); end
    n_checks++; if (mem_addr !== 32'h328) begin n_fails++; $display("[TB] FAIL sat_cut_addr: got %h want 00000328", mem_addr); end
    advance_masters();
    tick();
    n_checks++; if ({mem_we, mem_src} !== 2'b10) begin n_fails++; $display("[TB] FAIL sat_m0_beat we/src: got %b want 10", {mem_we, mem_src}); end
    n_checks++; if (mem_data !== 32'h5000) begin n_fails++; $display("[TB] FAIL sat_m0_data: got %h want 00005000", mem_data); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    m0_addr = 32'h600; m0_data = 32'h6000; m0_req = 1'b1;
    tick();
    tick();
    n_checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h600}) begin n_fails++; $display("[TB] FAIL rstmid_pre we/addr: got %b/%h want 1/00000600", mem_we, mem_addr); end
    advance_masters();
    rst = 1'b1;
    #1;
    n_checks++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin n_fails++; $display("[TB] FAIL rstmid_async gnt0/gnt1/we: got %b want 000", {m0_gnt, m1_gnt, mem_we}); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL rstmid_addr: got %h want 0", mem_addr); end
    m0_req = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin n_fails++; $display("[TB] FAIL rstmid_idle gnt0/gnt1/we: got %b want 000", {m0_gnt, m1_gnt, mem_we}); end
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fails++; $display("[TB] FAIL rstmid_last_restored gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    $display("[TB] mem_arbiter directed test start");
    test_reset();
    test_single_m0();
    test_both_idle();
`ifdef MEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_stream();
    test_saturate();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-master write-port arbiter sharing the single data-memory write port of `mem_ctrl` between the CPU `core` (master 0) and a second writer (master 1: loader or debug).
- Sits between the masters and `mem_ctrl`.
- Grants by round-robin with a bounded burst length, and presents one registered write per accepted beat to `mem_ctrl`.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: write data width.
- `MAX_BURST`, default 4: maximum consecutive beats for one master while the other is requesting; legal values ≥ 1.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `m0_req` in 1: core write request.
- `m0_addr` in AW: core write address.
- `m0_data` in DW: core write data.
- `m0_gnt` out 1: core grant.
- `m1_req` in 1: master 1 write request.
- `m1_addr` in AW: master 1 write address.
- `m1_data` in DW: master 1 write data.
- `m1_gnt` out 1: master 1 grant.
- `mem_addr` out AW: to `mem_ctrl` `addr`.
- `mem_data` out DW: to `mem_ctrl` `data`.
- `mem_we` out 1: to `mem_ctrl` `we`.
- `mem_src` out 1: index of the master that issued the current `mem_we` beat.

## Operation
- Beat: a rising edge where `mN_req` and `mN_gnt` are both 1.
- While `mN_req`=1 and its beat has not occurred, the master holds `mN_addr` and `mN_data` stable.
- FSM states are IDLE, G0, G1. `m0_gnt` = (state==G0) and `m1_gnt` = (state==G1); both are registered and never high together.
- `last` register: the last granted master. Reset value 1, so m0 wins the first tie.
- `bcnt` counts beats in the current grant, 0..MAX_BURST.

Transitions from IDLE:
- Only one master requesting: go to that master's G state.
- Both requesting: go to G of the master ≠ `last`.
- Neither requesting: stay in IDLE.

Transitions from GN:
- Other master requesting and (`mN_req`=0 or `bcnt`==MAX_BURST after this edge's beat): go to G(other).
- Otherwise, if `mN_req`=0: go to IDLE.
- Otherwise: stay.

Counter and pointer rules:
- On entering any G state, `bcnt` clears to 0 and `last` takes the new owner.
- `bcnt` increments per beat and saturates at MAX_BURST.
- If the owner's request is still up when it hits the limit but no other master is requesting, the grant continues. `bcnt` stays saturated, and the next request from the other master forces the switch.

Output rules:
- On a beat, the outputs register the beat's address, data and source, and `mem_we` is set to 1.
- On a non-beat edge, `mem_we` is 0 and `mem_addr`, `mem_data` and `mem_src` hold their values.
- A dropped request with the grant still high is not a beat.

## Timing
- Reset values: `m0_gnt`=0, `m1_gnt`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `mem_src`=0, state IDLE, `bcnt`=0, `last`=1.
- Reset asserted mid-operation clears everything immediately (asynchronous). A beat accepted on that edge is discarded.
- Request to grant: `req` sampled high at edge n in IDLE gives `gnt` high after edge n. The first beat is at edge n+1, and `mem_we` is high for the cycle after edge n+1.
- Beat to `mem_we`: 1 cycle latency.
- Throughput: one beat per cycle while granted.
- A G0↔G1 handover costs no idle cycle: the new owner's first beat is on the edge after the switch.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - m0 always wins, both from IDLE and from G1: any `m0_req` preempts G1 at the next edge.
  - `MAX_BURST` and `bcnt` are ignored; `last` is unused.
- `MEM_ARB_FIXED_PRIO_EN` undefined: round-robin with burst limit as specified above.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding constants (IDLE=2'd0, G0=2'd1, G1=2'd2);
  - the default `MAX_BURST`;
  - the `bcnt` width rule, $clog2(MAX_BURST+1).
- One combinational sub-module, `mem_arb_pick`, computes the next owner from the two requests, the current owner, `last` and burst-limit status. The FSM, counter and output registers stay in `mem_arbiter`.

## Test plan
- Reset, then `m0_req` held high with addresses 0x10, 0x14, 0x18: `m0_gnt` rises one cycle after the request, and `mem_we` pulses for 3 consecutive cycles with `mem_addr` = 0x10/0x14/0x18 and `mem_src`=0.
- Both masters request from IDLE with `last`=1: m0 is granted first, then m1 after m0 releases; `mem_src` sequence is 0 then 1.
- Both masters stream continuously with MAX_BURST=4: beats alternate in groups of 4 (0,0,0,0,1,1,1,1,…) with no gap cycle at handovers.
- `m1` bursts alone for 10 beats, then `m0_req` rises: m1 is cut off at the next edge (`bcnt` already saturated), and m0 gets the following beat.
- `rst` pulsed mid-burst while `mem_we`=1: grants and `mem_we` drop to 0 in the same cycle, `mem_addr` reads 0, and the state is IDLE after release.
- With `MEM_ARB_FIXED_PRIO_EN`, m1 streaming, then `m0_req` rises: `m1_gnt` falls and `m0_gnt` rises at the next edge, and m0 keeps the grant indefinitely while requesting.
